stopwatch_core: RTL
===================

# stopwatch_core

Stopwatch timekeeping stage fed directly by the downcounter's `zero` pulse, configured to one pulse per 10 ms. It accumulates pulses into a BCD time value MM:SS.CC and implements start/stop, lap-freeze and clear control. It drives the seven-segment display path with a 24-bit packed BCD word.

## Interface
- `MAX_MIN`, default 59: highest minutes value before wrap to 00:00.00; legal range 1..99.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `tick`  in  1  one-cycle 100 Hz count pulse (downcounter `zero`).
- `start_stop`  in  1  one-cycle pulse (debounced, edge-detected upstream); toggles run state.
- `lap`  in  1  one-cycle pulse; freezes/releases the displayed time.
- `clear`  in  1  one-cycle pulse; zeroes the count; honoured only in STOPPED.
- `display`  out  24  BCD {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}, 4 bits each.
- `running`  out  1  high in RUNNING or LAP_HOLD.
- `lap_active`  out  1  high in LAP_HOLD.
- `rollover`  out  1  one-cycle pulse when the count wraps from MAX_MIN:59.99 to 00:00.00.

## Operation
- State machine:
  - STOPPED: `start_stop` goes to RUNNING; `clear` zeroes the live count; `lap` is ignored.
  - RUNNING: `start_stop` goes to STOPPED; `lap` copies the live count into the lap register and goes to LAP_HOLD; `clear` is ignored.
  - LAP_HOLD: `lap` goes to RUNNING, releasing the display; `start_stop` goes to STOPPED, also releasing the display; `clear` is ignored.
- Simultaneous control pulses: priority is `start_stop` > `lap` > `clear`. Only the highest-priority pulse acts; the others are dropped and not queued.
- Counting: the live count increments on a cycle with `tick`=1 when the current registered state is RUNNING or LAP_HOLD.
  - A tick in the same cycle as `start_stop` from STOPPED is not counted.
  - A tick in the same cycle as `start_stop` from RUNNING is counted.
- Digit arithmetic:
  - Centiseconds count 00..99; carry into seconds.
  - Seconds count 00..59; carry into minutes.
  - Minutes count 00..MAX_MIN, then wrap.
  - Every nibble always holds 0..9; no binary intermediate is exposed.
- Display source: the lap register in LAP_HOLD, otherwise the live count.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. State goes to STOPPED; live count and lap register go to 0.

## Timing
- Reset values: `display`=24'h000000, `running`=0, `lap_active`=0, `rollover`=0.
- All outputs are registered.
- Tick latency: a tick sampled on edge N changes `display` after edge N (visible in cycle N+1). This holds for RUNNING only; in LAP_HOLD the display stays frozen.
- State latency: a control pulse sampled on edge N updates `running`/`lap_active` after edge N.
- Lap release: the display shows the live count, including ticks accumulated during the hold, from the cycle after the releasing edge.
- `rollover` is high for exactly the cycle after the wrapping tick's edge. It is asserted in LAP_HOLD as well.
- Back-to-back ticks on consecutive cycles are legal and each is counted; the bench uses this to accelerate wrap tests.

## Structure
- Package `stopwatch_pkg` holds:
  - `sw_state_t` enum {STOPPED, RUNNING, LAP_HOLD};
  - `bcd_time_t` packed struct {min, sec, cs}, each 8-bit two-digit BCD;
  - constants `CS_MAX`=99 and `SEC_MAX`=59.
- Sub-module `bcd_mod_counter` is instantiated three times (cs, sec, min):
  - parameter `MAX`: two-digit BCD count 0..MAX;
  - inputs `inc` and `clr`; outputs `value[7:0]` and combinational `carry` = `inc` && value==MAX;
  - chaining: `inc` of each stage is the `carry` of the previous stage.

## Test plan
- Reset, then `start_stop`, then 150 ticks: `display`=24'h000150, `running`=1.
- RUNNING at 00:05.00, `lap`, 300 ticks: `display` holds 24'h000500 with `lap_active`=1. A second `lap` gives `display`=24'h000800 next cycle.
- Preload to 59:59.99 with MAX_MIN=59, one tick: `display`=24'h000000 and a single-cycle `rollover`. With MAX_MIN=9, 09:59.99 wraps to 0.
- Simultaneous pulses:
  - STOPPED at 00:01.23, `start_stop`+`clear` together: RUNNING, count stays 00:01.23.
  - Subsequent `clear` while running: ignored.
  - `start_stop` to stop, then `clear`: 24'h000000.
- Ticks while STOPPED: no count change. Tick coincident with stop: counted; tick coincident with start: not counted.
- Assert `reset_n` low mid-count in LAP_HOLD, between clock edges: all outputs are 0 immediately. After release, the first `start_stop` counts from 00:00.00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types, limits and BCD helpers for the stopwatch timekeeping stage.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      STOPPED  = 2'd0,
      RUNNING  = 2'd1,
      LAP_HOLD = 2'd2
   } sw_state_t;

   // Packs to {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}.
   typedef struct packed {
      logic [7:0] min;
      logic [7:0] sec;
      logic [7:0] cs;
   } bcd_time_t;

   localparam int CS_MAX  = 99;
   localparam int SEC_MAX = 59;

   // Two-digit BCD encoding of a small decimal constant (0..99).
   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Adds one to a two-digit BCD value. The caller handles the upper limit,
   // so the tens digit never goes past 9.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that counts 0..MAX and wraps to 0, with a carry
// out for chaining into the next more-significant stage.
module bcd_mod_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX = 99
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic [7:0] value_nxt,
   output logic       carry
);

   localparam logic [7:0] MAX_BCD = to_bcd(MAX);

   // Carry is combinational so a whole chain advances on the same edge.
   assign carry = inc && (value == MAX_BCD);

   // Next value; exposed so the parent can register outputs in step with us.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      value_nxt = value;
      if (clr)
         value_nxt = 8'h00;
      else if (inc)
         value_nxt = (value == MAX_BCD) ? 8'h00 : bcd_inc(value);
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!reset_n)
         value <= 8'h00;
      else
         value <= value_nxt;
   end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: accumulates 100 Hz ticks into MM:SS.CC BCD with
// start/stop, lap freeze and clear control. All outputs are registered.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int MAX_MIN = 59
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   output logic [23:0] display,
   output logic        running,
   output logic        lap_active,
   output logic        rollover
);

   sw_state_t  state, state_nxt;
   bcd_time_t  live, live_nxt, lap_q, lap_nxt;
   logic [7:0] cs_val, sec_val, min_val;
   logic [7:0] cs_nxt, sec_nxt, min_nxt;
   logic       count_en, clr_en;
   logic       cs_carry, sec_carry, min_carry;

   assign live     = '{min: min_val, sec: sec_val, cs: cs_val};
   assign live_nxt = '{min: min_nxt, sec: sec_nxt, cs: cs_nxt};

   // Counting follows the registered state: a tick alongside the starting
   // pulse is dropped, a tick alongside the stopping pulse is kept.
   assign count_en = tick && (state == RUNNING || state == LAP_HOLD);

   // Control decode; start_stop outranks lap, which outranks clear.
   always_comb begin
      state_nxt = state;
      lap_nxt   = lap_q;
      clr_en    = 1'b0;
      case (state)
         STOPPED: begin
            if (start_stop)
               state_nxt = RUNNING;
            else if (!lap && clear)
               clr_en = 1'b1;
         end
         RUNNING: begin
            if (start_stop) begin
               state_nxt = STOPPED;
            end else if (lap) begin
               state_nxt = LAP_HOLD;
               lap_nxt   = live;
            end
         end
         LAP_HOLD: begin
            if (start_stop)
               state_nxt = STOPPED;
            else if (lap)
               state_nxt = RUNNING;
         end
         default: state_nxt = STOPPED;
      endcase
   end

   bcd_mod_counter #(.MAX(CS_MAX)) u_cs (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (count_en),
      .clr       (clr_en),
      .value     (cs_val),
      .value_nxt (cs_nxt),
      .carry     (cs_carry)
   );

   bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (cs_carry),
      .clr       (clr_en),
      .value     (sec_val),
      .value_nxt (sec_nxt),
      .carry     (sec_carry)
   );

   bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (sec_carry),
      .clr       (clr_en),
      .value     (min_val),
      .value_nxt (min_nxt),
      .carry     (min_carry)
   );

   // State and lap snapshot registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= STOPPED;
         lap_q <= '0;
      end else begin
         state <= state_nxt;
         lap_q <= lap_nxt;
      end
   end

   // Output registers, loaded from next-state values so they track the
   // state and count registers without an extra cycle of delay.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         display    <= 24'h000000;
         running    <= 1'b0;
         lap_active <= 1'b0;
         rollover   <= 1'b0;
      end else begin
         display    <= (state_nxt == LAP_HOLD) ? lap_nxt : live_nxt;
         running    <= (state_nxt != STOPPED);
         lap_active <= (state_nxt == LAP_HOLD);
         rollover   <= min_carry;
      end
   end

endmodule
